// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared slice width and FSM state type for the sequential subtractor
package arith_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_e;

endpackage

// File: rtl/borrow_lookahead4.sv
// rtl/borrow_lookahead4.sv - combinational 4-bit subtract slice with fully expanded borrow lookahead
module borrow_lookahead4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] diff,
    output logic       bout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] br;

    assign g = ~a & b;
    assign p = ~(a ^ b);

    // Every borrow is a flat sum of products of g/p/bin so no borrow waits on another.
    assign br[0] = bin;
    assign br[1] = g[0] | (p[0] & bin);
    assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & bin);
    assign br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bin);

    assign diff = a ^ b ^ br[3:0];
    assign bout = br[4];

endmodule

// File: rtl/borrow_lookahead_sub_seq.sv
// rtl/borrow_lookahead_sub_seq.sv - sequential subtractor resolving one 4-bit lookahead slice per cycle
module borrow_lookahead_sub_seq
    import arith_pkg::*;
#(
    parameter  int WIDTH  = 16,
    localparam int SLICES = WIDTH / SLICE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int MSB   = WIDTH - 1;

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [SLICE_W-1:0] sl_a;
    logic [SLICE_W-1:0] sl_b;
    logic [SLICE_W-1:0] sl_diff;
    logic               sl_bout;
    logic               last_slice;

    assign sl_a       = a_q[idx_q*SLICE_W +: SLICE_W];
    assign sl_b       = b_q[idx_q*SLICE_W +: SLICE_W];
    assign last_slice = (idx_q == IDX_W'(SLICES - 1));

    // borrow_q is the only carry between slices; the slice itself has no ripple.
    borrow_lookahead4 u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .bin  (borrow_q),
        .diff (sl_diff),
        .bout (sl_bout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        diff_d   = diff_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    idx_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                acc_d[idx_q*SLICE_W +: SLICE_W] = sl_diff;
                borrow_d = sl_bout;
                idx_d    = idx_q + IDX_W'(1);
                if (last_slice) begin
                    // Visible results change only here, so they stay put through IDLE/BUSY.
                    diff_d  = acc_d;
                    bout_d  = sl_bout;
                    zero_d  = (acc_d == '0);
                    ovf_d   = (a_q[MSB] != b_q[MSB]) && (acc_d[MSB] != a_q[MSB]);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            diff_q   <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            diff_q   <= diff_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_borrow_lookahead_sub_seq.sv
// tb/tb_borrow_lookahead_sub_seq.sv - directed and randomized checks of the sequential subtractor
module tb_borrow_lookahead_sub_seq;

    localparam int W   = 16;
    localparam int LAT = W / 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    borrow_lookahead_sub_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                         output logic [W-1:0] ed, output logic eb, output logic ez,
                         output logic eo);
        int ud;
        int sd;
        ud = int'(ta) - int'(tb_) - int'(tbin);
        sd = int'($signed(ta)) - int'($signed(tb_)) - int'(tbin);
        eb = (ud < 0);
        ed = W'(ud + (eb ? (1 << W) : 0));
        ez = (ed == '0);
        eo = (sd > 32767) || (sd < -32768);
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                          input int hold);
        logic [W-1:0] ed;
        logic         eb;
        logic         ez;
        logic         eo;
        int           cyc;
        model(ta, tb_, tbin, ed, eb, ez, eo);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_;
        bin       = tbin;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        bin      = 1'($urandom);
        cyc      = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!out_valid && cyc < 20);
        check("latency", cyc, LAT);
        check("diff", diff, ed);
        check("bout", bout, eb);
        check("zero", zero, ez);
        check("ovf", ovf, eo);
        for (int i = 0; i < hold; i++) begin
            in_valid = (i == 0);
            a        = ~ta;
            b        = ~tb_;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_diff", diff, ed);
            check("bp_flags", {bout, zero, ovf}, {eb, ez, eo});
        end
        // in_valid high across the DONE->IDLE edge must not start a new operation.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("ret_in_ready", in_ready, 1);
        check("ret_out_valid", out_valid, 0);
        check("held_diff", diff, ed);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_flags", {bout, zero, ovf}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h0034, 1'b0, 0);
        run_op(16'h0000, 16'h0001, 1'b0, 0);
        run_op(16'h8000, 16'h0001, 1'b0, 0);
        run_op(16'h5A5A, 16'h5A5A, 1'b0, 0);
        run_op(16'h5A5A, 16'h5A5A, 1'b1, 0);
        run_op(16'h0000, 16'h0000, 1'b1, 0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 0);
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 0);
        run_op(16'hABCD, 16'h1111, 1'b1, 3);

        // Abort mid-BUSY: reset must clear everything and suppress out_valid.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'h9999;
        b        = 16'h1111;
        bin      = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_diff", diff, 0);
        check("abort_flags", {bout, zero, ovf}, 3'b000);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_valid", out_valid, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0003, 16'h0001, 1'b0, 0);

        for (int i = 0; i < 24; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/borrow_lookahead_sub_seq.md
BORROW_LOOKAHEAD_SUB_SEQ -- requirements
Module: borrow_lookahead_sub_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 SHALL have parameter SLICES, default WIDTH/4: number of 4-bit slices; derived, not overridden.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operands are presented.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-007 SHALL have port a, input, WIDTH bits: minuend.
REQ-008 SHALL have port b, input, WIDTH bits: subtrahend.
REQ-009 SHALL have port bin, input, 1 bit: borrow-in.
REQ-010 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port diff, output, WIDTH bits: a - b - bin, modulo 2^WIDTH.
REQ-013 SHALL have port bout, output, 1 bit: borrow-out; 1 iff a < b + bin, unsigned.
REQ-014 SHALL have port zero, output, 1 bit: diff == 0.
REQ-015 SHALL have port ovf, output, 1 bit: two's-complement overflow.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY and DONE.
- IDLE: in_ready=1, out_valid=0.
- BUSY: in_ready=0, out_valid=0.
- DONE: in_ready=0, out_valid=1.
REQ-017 SHALL accept operands on a rising edge where in_valid && in_ready; on that edge it SHALL register a, b and bin, clear the slice index to 0 and go IDLE->BUSY.
REQ-018 SHALL ignore a, b, bin and in_valid whenever in_ready=0.
REQ-019 SHALL, in BUSY, resolve exactly one 4-bit slice per cycle, LSB slice first.
- Slice k uses bits [4k+3:4k] and the borrow-in from slice k-1; bin for k=0.
REQ-020 SHALL compute each slice with borrow lookahead.
- Per bit: Gi = ~Ai & Bi, Pi = ~(Ai ^ Bi), Di = Ai ^ Bi ^ Bri.
- Borrow rule: Br(i+1) = Gi | (Pi & Bri), fully expanded per bit, with no ripple inside the slice.
REQ-021 SHALL go BUSY->DONE on the edge that resolves slice SLICES-1; out_valid SHALL rise exactly SLICES cycles after the accept edge (4 for WIDTH=16).
REQ-022 SHALL hold diff, bout, zero and ovf stable while out_valid && !out_ready.
REQ-023 SHALL go DONE->IDLE on an edge where out_valid && out_ready; no new operand SHALL be accepted on that same edge.
REQ-024 SHALL define the flags as follows.
- bout = final slice borrow-out.
- zero = (diff == 0).
- ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
REQ-025 SHALL handle wrap-around cases as follows.
- a < b + bin: diff = a - b - bin + 2^WIDTH, bout=1.
- a=0, b=0, bin=1: diff = all ones, bout=1.
REQ-026 SHALL keep diff, bout, zero and ovf at their last values in IDLE and BUSY; they SHALL be meaningful only while out_valid=1.

Reset
REQ-027 SHALL, while rst_n=0 (asynchronous), force: state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, zero=0, ovf=0, slice index=0, operand registers=0.
REQ-028 SHALL, when reset is asserted mid-BUSY or mid-DONE, discard the operation with no out_valid pulse; the first accept after rst_n rises SHALL behave normally.

Structure
REQ-029 SHALL place the FSM state enum and the slice width constant (4) in shared package arith_pkg.
REQ-030 SHALL instantiate a single combinational sub-module borrow_lookahead4 (4-bit a, b, bin in; 4-bit diff, bout out), reused across cycles.
REQ-031 SHALL contain no multi-bit ripple chain; the only cross-slice borrow SHALL be one registered bit.

Verification (WIDTH=16)
REQ-032 Basic subtract: a=0x1234, b=0x0034, bin=0 -> diff=0x1200, bout=0, zero=0, ovf=0; out_valid exactly 4 cycles after accept.
REQ-033 Underflow: a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0.
REQ-034 Signed overflow: a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, ovf=1.
REQ-035 Equal operands and borrow-in: a=b=0x5A5A, bin=0 -> diff=0x0000, zero=1; then bin=1 -> diff=0xFFFF, bout=1, zero=0.
REQ-036 Backpressure: out_ready=0 for 3 cycles in DONE -> outputs constant, in_ready=0, an in_valid pulse is ignored; out_ready=1 -> IDLE next cycle.
REQ-037 Reset abort: rst_n=0 during BUSY cycle 2 -> immediate IDLE, all outputs 0, no out_valid; the next operation (0x0003-0x0001) -> diff=0x0002.
